// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : issue_scheduler
// Purpose  : Per-FU round-robin issue arbiter between the reservation station
//            and the execution units. Each FU gets a valid/ready offer and the
//            RS gets a one-hot clear for every accepted entry.
// Options  : ISSUE_STATS_EN adds per-FU saturating issue and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module issue_scheduler #(
    parameter int RS_ENTRIES = 8,
    parameter int NUM_FUS    = 2,
    parameter int IDX_W      = $clog2(RS_ENTRIES),
    parameter int FU_W       = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [RS_ENTRIES-1:0]       reqs,
    input  logic [RS_ENTRIES*FU_W-1:0]  req_fu,
    input  logic [NUM_FUS-1:0]          fu_ready,
    output logic [NUM_FUS-1:0]          issue_valid,
    output logic [NUM_FUS*IDX_W-1:0]    issue_idx,
    output logic [RS_ENTRIES-1:0]       issue_clear
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    logic [NUM_FUS-1:0]                 w_hs;
    logic [NUM_FUS-1:0][RS_ENTRIES-1:0] w_clr;

    // Returns {found, index} of the first set bit at or above base, wrapping.
    function automatic logic [IDX_W:0] f_pick(input logic [RS_ENTRIES-1:0] cand,
                                              input logic [IDX_W-1:0]      base);
        logic             found;
        logic [IDX_W-1:0] sel;
        int               j;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < RS_ENTRIES; k++) begin
            j = int'(base) + k;
            if (j >= RS_ENTRIES) j = j - RS_ENTRIES;
            if (!found && cand[j]) begin
                found = 1'b1;
                sel   = IDX_W'(j);
            end
        end
        return {found, sel};
    endfunction

    for (genvar f = 0; f < NUM_FUS; f++) begin : g_fu
        state_t                r_state, w_state_nxt;
        logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
        logic [IDX_W-1:0]      r_idx, w_idx_nxt;
        logic [IDX_W-1:0]      w_idx_inc, w_base, w_sel;
        logic [RS_ENTRIES-1:0] w_cand;
        logic                  w_found, w_offer;

        assign w_offer   = (r_state == S_OFFER);
        // Reset also blocks the handshake so a discarded offer never clears.
        assign w_hs[f]   = w_offer & fu_ready[f] & ~flush & ~rst;
        assign w_idx_inc = (r_idx == IDX_W'(RS_ENTRIES-1)) ? '0 : r_idx + IDX_W'(1);
        assign w_base    = w_hs[f] ? w_idx_inc : r_ptr;

        for (genvar i = 0; i < RS_ENTRIES; i++) begin : g_cand
            assign w_cand[i] = reqs[i]
                             & (req_fu[i*FU_W +: FU_W] == FU_W'(f))
                             & ~(w_offer & (r_idx == IDX_W'(i)));
        end

        assign {w_found, w_sel} = f_pick(w_cand, w_base);

        always_comb begin
            w_state_nxt = r_state;
            w_ptr_nxt   = r_ptr;
            w_idx_nxt   = r_idx;
            if (flush) begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_found) begin
                            w_idx_nxt   = w_sel;
                            w_state_nxt = S_OFFER;
                        end
                    end
                    S_OFFER: begin
                        if (w_hs[f]) begin
                            w_ptr_nxt = w_idx_inc;
                            if (w_found) begin
                                w_idx_nxt = w_sel;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_ptr   <= '0;
                r_idx   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_ptr   <= w_ptr_nxt;
                r_idx   <= w_idx_nxt;
            end
        end

        assign issue_valid[f]              = w_offer;
        assign issue_idx[f*IDX_W +: IDX_W] = r_idx;
        assign w_clr[f] = w_hs[f] ? (RS_ENTRIES'(1) << r_idx) : '0;
    end

    always_comb begin
        issue_clear = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            issue_clear = issue_clear | w_clr[f];
        end
    end

`ifdef ISSUE_STATS_EN
    logic [31:0] issue_cnt [NUM_FUS];
    logic [31:0] stall_cnt [NUM_FUS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NUM_FUS; f++) begin
                issue_cnt[f] <= '0;
                stall_cnt[f] <= '0;
            end
        end else begin
            for (int f = 0; f < NUM_FUS; f++) begin
                if (w_hs[f] && (issue_cnt[f] != '1)) issue_cnt[f] <= issue_cnt[f] + 32'd1;
                if (issue_valid[f] && !fu_ready[f] && (stall_cnt[f] != '1))
                    stall_cnt[f] <= stall_cnt[f] + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_scheduler
// Purpose  : Directed self-checking bench for issue_scheduler (8 entries, 2 FUs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] reqs;
    logic [7:0] req_fu;
    logic [1:0] fu_ready;
    logic [1:0] issue_valid;
    logic [5:0] issue_idx;
    logic [7:0] issue_clear;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    issue_scheduler #(
        .RS_ENTRIES (8),
        .NUM_FUS    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .reqs        (reqs),
        .req_fu      (req_fu),
        .fu_ready    (fu_ready),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issue_clear (issue_clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; reqs = '0; req_fu = '0; fu_ready = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_valid", issue_valid, 2'b00);
        check("rst_idx",   issue_idx,   6'd0);
        check("rst_clear", issue_clear, 8'h00);
        check("rst_ptr0",  dut.g_fu[0].r_ptr, 3'd0);

        // Single entry 2 to FU0
        reqs = 8'b0000_0100; req_fu = 8'h00; fu_ready = 2'b01;
        tick();
        check("single_valid", issue_valid,    2'b01);
        check("single_idx0",  issue_idx[2:0], 3'd2);
        check("single_clear", issue_clear,    8'b0000_0100);
        tick();
        reqs = '0; #1;
        check("single_ptr0",  dut.g_fu[0].r_ptr, 3'd3);
        check("single_idle",  issue_valid, 2'b00);

        // Flush to bring ptr0 back to 0
        flush = 1'b1; tick(); flush = 1'b0; #1;
        check("flush_ptr0", dut.g_fu[0].r_ptr, 3'd0);

        // Round-robin over entries 1, 5, 7 with wrap
        reqs = 8'b1010_0010; req_fu = 8'h00; fu_ready = 2'b01;
        tick();
        check("rr_idx_1",   issue_idx[2:0], 3'd1);
        check("rr_clr_1",   issue_clear,    8'b0000_0010);
        tick();
        reqs = 8'b1010_0000; #1;
        check("rr_idx_5",   issue_idx[2:0], 3'd5);
        check("rr_clr_5",   issue_clear,    8'b0010_0000);
        tick();
        reqs = 8'b1000_0000; #1;
        check("rr_idx_7",   issue_idx[2:0], 3'd7);
        check("rr_clr_7",   issue_clear,    8'b1000_0000);
        tick();
        reqs = '0; #1;
        check("rr_idle",    issue_valid, 2'b00);
        check("rr_ptr_wrap", dut.g_fu[0].r_ptr, 3'd0);

        // Backpressure on FU1, entry 3
        reqs = 8'b0000_1000; req_fu = 8'b0000_1000; fu_ready = 2'b00;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", issue_valid[1],  1'b1);
            check("bp_idx1",  issue_idx[5:3],  3'd3);
            check("bp_clear", issue_clear,     8'h00);
            tick();
        end
        fu_ready = 2'b10; #1;
        check("bp_clear_acc", issue_clear, 8'b0000_1000);
`ifdef ISSUE_STATS_EN
        check("bp_stall_cnt", dut.stall_cnt[1], 32'd4);
`endif
        tick();
        reqs = '0; fu_ready = 2'b00; #1;
        check("bp_idle", issue_valid, 2'b00);
        check("bp_ptr1", dut.g_fu[1].r_ptr, 3'd4);
`ifdef ISSUE_STATS_EN
        check("bp_issue_cnt", dut.issue_cnt[1], 32'd1);
`endif

        // Parallel FUs: entry 0 -> FU0, entry 1 -> FU1
        reqs = 8'b0000_0011; req_fu = 8'b0000_0010; fu_ready = 2'b11;
        tick();
        check("par_valid", issue_valid, 2'b11);
        check("par_idx",   issue_idx,   {3'd1, 3'd0});
        check("par_clear", issue_clear, 8'b0000_0011);
        tick();
        reqs = '0; #1;
        check("par_idle",  issue_valid, 2'b00);

        // Flush colliding with FU0 handshake on entry 6
        reqs = 8'b0100_0000; req_fu = 8'h00; fu_ready = 2'b01;
        tick();
        check("fc_idx0", issue_idx[2:0], 3'd6);
        flush = 1'b1; #1;
        check("fc_clear", issue_clear, 8'h00);
        tick();
        flush = 1'b0; reqs = '0; #1;
        check("fc_valid", issue_valid, 2'b00);
        check("fc_ptr0",  dut.g_fu[0].r_ptr, 3'd0);

        // Reset while FU1 offers entry 4
        reqs = 8'b0001_0000; req_fu = 8'b0001_0000; fu_ready = 2'b00;
        tick();
        check("rm_offer", issue_idx[5:3], 3'd4);
        rst = 1'b1; fu_ready = 2'b10; #1;
        check("rm_clear_rst", issue_clear, 8'h00);
        tick();
        rst = 1'b0; reqs = '0; fu_ready = 2'b00; #1;
        check("rm_valid", issue_valid, 2'b00);
        check("rm_idx",   issue_idx,   6'd0);
        check("rm_clear", issue_clear, 8'h00);
        check("rm_ptr1",  dut.g_fu[1].r_ptr, 3'd0);
`ifdef ISSUE_STATS_EN
        check("rm_stall_cnt", dut.stall_cnt[1], 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_scheduler.md
# issue_scheduler

Per-functional-unit issue arbiter between the reservation station and the execution units. Each cycle it watches the ready-request vector from the RS entries and picks one entry for each FU with a rotating (round-robin) priority. It holds that offer stable on a valid/ready handshake and pulses a one-hot clear back to the RS when the FU accepts.

## Interface
Parameters:
- RS_ENTRIES, 8, number of RS entries; must be at least 2
- NUM_FUS, 2, number of functional units; must be at least 1
- IDX_W, $clog2(RS_ENTRIES), entry index width
- FU_W, $clog2(NUM_FUS) (min 1), FU-select width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; drops all offers
- reqs  in  RS_ENTRIES  entry i is operand-ready and requests issue
- req_fu  in  RS_ENTRIES*FU_W  target FU of entry i, in slice [i*FU_W +: FU_W]
- fu_ready  in  NUM_FUS  FU f accepts an instruction this cycle
- issue_valid  out  NUM_FUS  offer valid to FU f
- issue_idx  out  NUM_FUS*IDX_W  offered entry index for FU f
- issue_clear  out  RS_ENTRIES  one-hot per FU: entry accepted this cycle, so the RS frees it

## Operation
- One independent controller per FU with two states, IDLE and OFFER, and a round-robin pointer ptr[f] of IDX_W bits.
- Candidates for FU f: reqs[i] & (req_fu slice i == f), minus any entry currently offered by this FU, minus the entry being accepted this cycle.
- Selection: the first candidate scanning upward from ptr[f], wrapping from RS_ENTRIES-1 to 0.
- IDLE: if a candidate exists, register its index into issue_idx[f], set issue_valid[f]=1 and go to OFFER. Otherwise stay in IDLE.
- OFFER: issue_idx[f] is held stable while fu_ready[f]=0.
- On handshake (issue_valid[f] & fu_ready[f] & ~flush):
  - issue_clear[issue_idx[f]]=1, combinationally, in the same cycle.
  - ptr[f] <= issue_idx[f]+1, modulo RS_ENTRIES.
  - If another candidate exists, load it and stay in OFFER (back-to-back issue). Otherwise go to IDLE.
- An offered entry must keep reqs high until accepted. Withdrawal happens only through flush. A drop of reqs while offered is an RS protocol error, and the scheduler keeps offering.
- flush:
  - Next state is IDLE for every FU; issue_valid goes 0.
  - All ptr reset to 0.
  - issue_clear is forced to 0 in the flush cycle.
- Reset values: issue_valid=0, issue_idx=0, issue_clear=0, all ptr=0, all FSMs IDLE.

## Timing
- Request to offer: reqs rising at edge N gives issue_valid high after edge N+1 (1 cycle, registered).
- issue_clear is combinational from fu_ready, in the handshake cycle. The RS drops the entry at the following edge.
- Back-to-back: with 2+ candidates, the FU sees a new valid offer on the cycle after each acceptance, so throughput is 1 issue per cycle per FU.
- Simultaneous events:
  - flush wins over a handshake.
  - rst wins over flush.
  - Candidate sets of different FUs are disjoint because each entry targets one FU, so at most NUM_FUS bits of issue_clear are set per cycle.
- Reset mid-offer: the offer is discarded and nothing is cleared.

## Configuration
- ISSUE_STATS_EN: when defined, adds per-FU 32-bit counters, readable hierarchically as issue_cnt[f] and stall_cnt[f]:
  - issue_cnt[f] counts handshakes.
  - stall_cnt[f] counts cycles with issue_valid[f]=1 & fu_ready[f]=0.
  - Both counters reset on rst, not on flush, and saturate at all-ones.
- When undefined, no counters exist and the logic is otherwise identical.

## Test plan
- Single entry: after reset, reqs=8'b0000_0100 with req_fu[2]=0 and fu_ready[0]=1 -> issue_valid[0]=1 and issue_idx[0]=2 one cycle later; issue_clear=8'b0000_0100 in that cycle; ptr[0]=3.
- Round-robin wrap: entries 1, 5 and 7 request FU0, fu_ready=1 held, with the RS dropping each entry after its clear -> issue order 1, 5, 7 on consecutive cycles; ptr[0] wraps to 0.
- Backpressure: entry 3 offered to FU1 with fu_ready[1]=0 for 4 cycles -> issue_idx[1] stays 3 and issue_clear=0 throughout; clear asserts on the cycle fu_ready[1]=1. With ISSUE_STATS_EN, stall_cnt[1]=4.
- Parallel FUs: entry 0 targets FU0 and entry 1 targets FU1, both FUs ready -> both offered in the same cycle; issue_clear=8'b0000_0011.
- Flush collision: flush=1 in the same cycle as an FU0 handshake on entry 6 -> issue_clear=0; next cycle issue_valid=0 and ptr[0]=0.
- Reset mid-offer: rst=1 while in OFFER -> all outputs are 0 after the edge and no clear is ever pulsed for the dropped entry.
